fifo_gen2: RTL and testbench

FIFO_GEN2 -- requirements
Module: fifo_gen2

---
 rtl/fifo_gen2.sv | 151 +++++++++++++++
 tb/tb_fifo_gen2.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_gen2.sv
// fifo_gen2: single-clock FIFO with arbitrary depth, a registered or
// first-word-fall-through read port, level flags and registered status pulses.
//
// Handshake semantics: a write is taken on a rising edge when wr_en is high,
// flush is low and there is room (or a read is taken in the same cycle). A read
// is taken when rd_en is high, flush is low and at least one word is already
// stored. In registered mode valid pulses for one cycle with the popped word on
// data_out. In fall-through mode valid is a level that qualifies the head word.
module fifo_gen2 #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 8,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    localparam int CNT_W    = $clog2(DEPTH + 1),
    localparam int PTR_W    = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              wr_ack,
    output logic              overflow,
    output logic              underflow,
    output logic              full,
    output logic              empty,
    output logic              almostfull,
    output logic              almostempty,
    output logic [CNT_W-1:0]  count
);

    // Storage is deliberately not reset; pointers and count define what is live.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_ack_q, wr_ack_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_acc;
    logic             wr_acc;

    // Accept decisions, pointer/count updates and status pulses for the next edge.
    always_comb begin
        rd_acc      = rd_en && !flush && (count_q != '0);
        wr_acc      = wr_en && !flush && ((count_q < CNT_W'(DEPTH)) || rd_acc);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wr_ack_d    = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Explicit wrap so non-power-of-two depths work.
            if (wr_acc) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count_d = count_q + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - 1'b1;
            end
            wr_ack_d    = wr_acc;
            overflow_d  = wr_en && !wr_acc;
            underflow_d = rd_en && !rd_acc;
        end
    end

    // Control state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally whenever something is stored.
            assign data_out = (count_q != '0) ? mem[rd_ptr_q] : '0;
            assign valid    = (count_q != '0);
        end else begin : g_std
            logic [DATA_W-1:0] data_out_q, data_out_d;
            logic              valid_q, valid_d;

            // Registered read: capture the head on an accepted pop, otherwise hold.
            always_comb begin
                data_out_d = data_out_q;
                valid_d    = 1'b0;
                if (rd_acc) begin
                    data_out_d = mem[rd_ptr_q];
                    valid_d    = 1'b1;
                end
            end

            // Read data register with asynchronous clear.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_out_q <= '0;
                    valid_q    <= 1'b0;
                end else begin
                    data_out_q <= data_out_d;
                    valid_q    <= valid_d;
                end
            end

            assign data_out = data_out_q;
            assign valid    = valid_q;
        end
    endgenerate

    assign count       = count_q;
    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= CNT_W'(AF_THRESH));
    assign almostempty = (count_q <= CNT_W'(AE_THRESH));

endmodule

// File: tb/tb_fifo_gen2.sv
// tb_fifo_gen2: drives a registered-read and a fall-through instance with the
// same stimulus and compares both against a queue-based reference model.
module tb_fifo_gen2;

    localparam int DW    = 16;
    localparam int DEPTH = 5;
    localparam int CW    = $clog2(DEPTH + 1);

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] dout0, dout1;
    logic          valid0, valid1, ack0, ack1, ov0, ov1, un0, un1;
    logic          full0, full1, empty0, empty1, af0, af1, ae0, ae1;
    logic [CW-1:0] cnt0, cnt1;

    fifo_gen2 #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(4), .AE_THRESH(1)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(dout0), .valid(valid0), .wr_ack(ack0),
        .overflow(ov0), .underflow(un0), .full(full0), .empty(empty0),
        .almostfull(af0), .almostempty(ae0), .count(cnt0)
    );

    fifo_gen2 #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(4), .AE_THRESH(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(dout1), .valid(valid1), .wr_ack(ack1),
        .overflow(ov1), .underflow(un1), .full(full1), .empty(empty1),
        .almostfull(af1), .almostempty(ae1), .count(cnt1)
    );

    // Reference model: stored words as a queue plus expected registered outputs.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_dout0 = '0;
    logic          exp_valid0 = 1'b0;
    logic          exp_ack = 1'b0;
    logic          exp_ov = 1'b0;
    logic          exp_un = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = exp_q.size();
        chk({tag, ":count_std"}, 32'(cnt0), n);
        chk({tag, ":count_fwft"}, 32'(cnt1), n);
        chk({tag, ":full"}, {31'd0, full0}, {31'd0, n == DEPTH});
        chk({tag, ":empty"}, {31'd0, empty0}, {31'd0, n == 0});
        chk({tag, ":almostfull"}, {31'd0, af0}, {31'd0, n >= 4});
        chk({tag, ":almostempty"}, {31'd0, ae0}, {31'd0, n <= 1});
        chk({tag, ":flags_fwft"}, {28'd0, full1, empty1, af1, ae1},
            {28'd0, n == DEPTH, n == 0, n >= 4, n <= 1});
        chk({tag, ":wr_ack"}, {30'd0, ack0, ack1}, {30'd0, exp_ack, exp_ack});
        chk({tag, ":overflow"}, {30'd0, ov0, ov1}, {30'd0, exp_ov, exp_ov});
        chk({tag, ":underflow"}, {30'd0, un0, un1}, {30'd0, exp_un, exp_un});
        chk({tag, ":valid_std"}, {31'd0, valid0}, {31'd0, exp_valid0});
        chk({tag, ":dout_std"}, 32'(dout0), 32'(exp_dout0));
        chk({tag, ":valid_fwft"}, {31'd0, valid1}, {31'd0, n > 0});
        if (n > 0) chk({tag, ":dout_fwft"}, 32'(dout1), 32'(exp_q[0]));
    endtask

    // One clock cycle of stimulus; the model advances from the pre-edge state.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic f,
                         input string tag);
        logic acc_r, acc_w;
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        flush   = f;
        acc_r = r && !f && (exp_q.size() > 0);
        acc_w = w && !f && ((exp_q.size() < DEPTH) || acc_r);
        @(posedge clk);
        if (f) begin
            exp_q.delete();
            exp_valid0 = 1'b0;
            exp_ack    = 1'b0;
            exp_ov     = 1'b0;
            exp_un     = 1'b0;
        end else begin
            exp_valid0 = acc_r;
            if (acc_r) exp_dout0 = exp_q.pop_front();
            if (acc_w) exp_q.push_back(d);
            exp_ack = acc_w;
            exp_ov  = w && !acc_w;
            exp_un  = r && !acc_r;
        end
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_dout0  = '0;
        exp_valid0 = 1'b0;
        exp_ack    = 1'b0;
        exp_ov     = 1'b0;
        exp_un     = 1'b0;
    endtask

    // Directed sequence followed by random traffic.
    initial begin
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full, then one rejected write.
        for (int i = 1; i <= 5; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0, "fill");
        chk("full_after_5", {31'd0, full0}, 32'd1);
        cycle(1'b1, 16'h0006, 1'b0, 1'b0, "overflow_write");
        chk("overflow_pulse", {31'd0, ov0}, 32'd1);
        chk("count_at_full", 32'(cnt0), 32'd5);

        // Drain, refill past the wrap point, drain again: 1..8 in order.
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0, "drain1");
        for (int i = 6; i <= 8; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0, "wrap_wr");
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, "wrap_rd");
        chk("last_word_8", 32'(dout0), 32'd8);

        // Simultaneous read/write at full and at empty.
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(16'h10 + i), 1'b0, 1'b0, "refill");
        cycle(1'b1, 16'h0020, 1'b1, 1'b0, "full_rw");
        chk("full_rw_no_ov", {31'd0, ov0}, 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0, "drain2");
        cycle(1'b1, 16'h0030, 1'b1, 1'b0, "empty_rw");
        chk("empty_rw_un", {31'd0, un0}, 32'd1);
        chk("empty_rw_cnt", 32'(cnt0), 32'd1);
        cycle(1'b0, '0, 1'b1, 1'b0, "drain3");

        // Fall-through head visibility.
        cycle(1'b1, 16'h00A5, 1'b0, 1'b0, "fwft_wr");
        chk("fwft_dout_a5", 32'(dout1), 32'h00A5);
        cycle(1'b0, '0, 1'b1, 1'b0, "fwft_rd");
        chk("fwft_valid_low", {31'd0, valid1}, 32'd0);

        // Flush with a concurrent write.
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(16'h40 + i), 1'b0, 1'b0, "pre_flush");
        cycle(1'b1, 16'h0050, 1'b0, 1'b1, "flush");
        chk("flush_no_ack", {31'd0, ack0}, 32'd0);
        cycle(1'b1, 16'h0051, 1'b0, 1'b0, "post_flush_wr");
        cycle(1'b0, '0, 1'b1, 1'b0, "post_flush_rd");
        chk("post_flush_word", 32'(dout0), 32'h0051);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), DW'($urandom_range(0, 16'hFFFF)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0), "rand");
        end

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(16'h60 + i), 1'b0, 1'b0, "burst");
        cycle(1'b1, 16'h0063, 1'b1, 1'b0, "burst_rw");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 16'h0077, 1'b0, 1'b0, "post_rst_wr");
        cycle(1'b1, 16'h0078, 1'b1, 1'b0, "post_rst_rw");
        chk("post_rst_first", 32'(dout0), 32'h0077);
        cycle(1'b0, '0, 1'b1, 1'b0, "post_rst_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
